shift_normalizer: RTL
=====================

// Module: shift_normalizer
// PURPOSE
//  Iterative normaliser: inverse companion of the team's 4-bit barrel shift datapath.
//  Takes a word and shifts it one position per cycle until the leading 1 sits at the
//  MSB. Reports the normalised word and the shift count, so that the datapath can
//  later restore the original word by shifting in the opposite direction.
//  Sits between a valid/ready producer and a valid/ready consumer.
// PARAMETERS
//  WIDTH   4                               data width in bits, >= 2
//  CNT_W   (WIDTH>1)?$clog2(WIDTH):1       shift-count width (derived, do not override)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input word offered
//  in_ready   out  1      block can accept (high only in IDLE)
//  in_data    in   WIDTH  word to normalise; sampled only on accept
//  in_dir     in   1      [NORM_DIR_EN only] 1 = normalise left (to MSB), 0 = right (to LSB)
//  out_valid  out  1      result held valid
//  out_ready  in   1      consumer takes result
//  out_data   out  WIDTH  normalised word
//  out_shift  out  CNT_W  number of positions shifted, 0..WIDTH-1
//  out_dir    out  1      [NORM_DIR_EN only] echo of accepted in_dir
//  out_zero   out  1      accepted word was all zeros
// BEHAVIOUR
//  - One clock (clk); rst_n asynchronous, active-low. All outputs are registered.
//  - Reset values: state = IDLE; in_ready = 0; out_valid = 0; out_data = 0;
//    out_shift = 0; out_zero = 0; out_dir = 1.
//  - First rising edge after rst_n deasserts: in_ready goes to 1.
//  - FSM has three states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready = 1.
//    - On the in_valid & in_ready edge: capture in_data (and in_dir).
//    - Clear the count, drop in_ready, go to SHIFT.
//  - SHIFT, evaluated each cycle:
//    - If data == 0, or the target bit is set (MSB when left, LSB when right):
//      go to DONE, set out_valid next edge, set out_zero = (data == 0).
//    - Otherwise shift data one position (zero fill) and increment the count.
//  - DONE: out_valid = 1 and out_* stay stable until out_valid & out_ready.
//    - Then drop out_valid and go to IDLE; in_ready goes to 1 on that same edge.
//    - out_ready is ignored outside DONE.
//  - Latency: with k = shift needed (leading zeros), out_valid is first high
//    k+1 edges after the accept edge. Maximum is WIDTH edges. All-zero input takes 1 edge.
//  - Throughput: one word per k+3 cycles minimum. There is no accept/deliver overlap:
//    in_valid while busy is ignored, because in_ready = 0.
//  - Count never wraps: k <= WIDTH-1 always fits CNT_W.
//  - Zero input: out_data = 0, out_shift = 0, out_zero = 1.
//  - rst_n asserted mid-operation: everything returns to reset values immediately.
//    The in-flight word is discarded and no out_valid is produced.
//  - Round-trip invariant: shifting out_data by out_shift in the direction opposite
//    to the normalisation reproduces the accepted word exactly.
// CONFIGURATION
//  - Macro NORM_DIR_EN.
//  - Defined: in_dir/out_dir ports exist. dir=0 normalises toward the LSB by
//    right-shifting with zero fill.
//  - Undefined: both ports are absent and normalisation is left-only (MSB target).
//    Timing and all other behaviour are identical.
// STRUCTURE
//  - Package shift_norm_pkg holds:
//    - typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_t
//    - localparams DIR_LEFT = 1'b1 and DIR_RIGHT = 1'b0
//    - function cnt_w(width) returning the CNT_W rule above
//  - Sub-module shift_norm_detect (combinational): given data and dir, outputs
//    target_hit and is_zero. The FSM, data register and counter stay in the top module.
// TESTING
//  - Reset: hold rst_n=0 -> in_ready=0, out_valid=0, out_data=0.
//    Release -> in_ready=1 after 1 edge.
//  - in_data=4'b0001, left -> out_data=4'b1000, out_shift=3, out_zero=0,
//    out_valid 4 edges after accept.
//  - in_data=4'b1010 -> out_data=4'b1010, out_shift=0, latency 1.
//    in_data=4'b0000 -> out_data=0, out_shift=0, out_zero=1, latency 1.
//  - Backpressure: in_data=4'b0110, out_ready=0 for 5 cycles -> out_data=4'b1100,
//    out_shift=1 held stable. A second in_valid during this time is not accepted.
//  - Mid-op reset: accept 4'b0001, pulse rst_n low at edge 2 -> no out_valid.
//    The next accept of 4'b0010 gives 4'b1000, out_shift=2.
//  - NORM_DIR_EN with in_dir=0: in_data=4'b1000 -> out_data=4'b0001, out_shift=3, out_dir=0.
//    Also check the round trip for all 16 inputs in both directions.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// Shared types and helpers for the shift normaliser.
// Optional feature macro: NORM_DIR_EN (selectable normalisation direction).
package shift_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Shift-count width: enough bits to hold 0..width-1, at least one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_normalizer_if.sv
// Producer/consumer handshake bundle for the shift normaliser.
// Optional feature macro: NORM_DIR_EN adds in_dir/out_dir.
interface shift_normalizer_if
  import shift_norm_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int CNT_W = cnt_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_shift;
  logic             out_zero;
`ifdef NORM_DIR_EN
  logic             in_dir;
  logic             out_dir;

  modport slave (
    input  in_valid, in_data, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_zero, out_dir
  );
  modport master (
    output in_valid, in_data, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_zero, out_dir
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_zero
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_zero
  );
`endif

endinterface

// File: rtl/shift_normalizer_detect.sv
// Combinational termination detect: has the leading 1 reached the target end,
// or is there no 1 at all.
module shift_norm_detect
  import shift_norm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  output logic             target_hit,
  output logic             is_zero
);

  assign target_hit = (dir == DIR_LEFT) ? data[WIDTH-1] : data[0];
  assign is_zero    = ~|data;

endmodule

// File: rtl/shift_normalizer.sv
// Iterative normaliser: shifts one position per cycle until the leading 1 sits
// at the target end, then reports the word and the number of positions moved.
// Optional feature macro: NORM_DIR_EN (in_dir selects left/right normalisation;
// without it the block normalises left only).
module shift_normalizer
  import shift_norm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  shift_normalizer_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  norm_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_shift_q, out_shift_d;
  logic             out_zero_q, out_zero_d;
  logic             out_dir_q, out_dir_d;

  logic accept;
  logic dir_in;
  logic target_hit;
  logic is_zero;
  logic finish;

`ifdef NORM_DIR_EN
  assign dir_in = bus.in_dir;
`else
  assign dir_in = DIR_LEFT;
`endif

  assign accept = in_ready_q & bus.in_valid;
  assign finish = target_hit | is_zero;

  shift_norm_detect #(.WIDTH(WIDTH)) u_detect (
    .data       (data_q),
    .dir        (dir_q),
    .target_hit (target_hit),
    .is_zero    (is_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = SHIFT;
      SHIFT:   if (finish)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    data_d      = data_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    out_zero_d  = out_zero_q;
    out_dir_d   = out_dir_q;
    case (state_q)
      IDLE: begin
        // Raised on the first edge out of reset; dropped on the accept edge.
        in_ready_d = ~accept;
        if (accept) begin
          data_d = bus.in_data;
          dir_d  = dir_in;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        if (finish) begin
          out_valid_d = 1'b1;
          out_data_d  = data_q;
          out_shift_d = cnt_q;
          out_zero_d  = is_zero;
          out_dir_d   = dir_q;
        end else begin
          data_d = (dir_q == DIR_LEFT) ? (data_q << 1) : (data_q >> 1);
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_LEFT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_zero_q  <= 1'b0;
      out_dir_q   <= DIR_LEFT;
    end else begin
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
      out_zero_q  <= out_zero_d;
      out_dir_q   <= out_dir_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_zero  = out_zero_q;
`ifdef NORM_DIR_EN
  assign bus.out_dir   = out_dir_q;
`else
  // Direction echo only exists as a port when direction is selectable.
  logic unused_dir;
  assign unused_dir = out_dir_q;
`endif

endmodule
